// File: rtl/mb8_word_master_pkg.sv
// mb8_pkg: shared types and widths for the 8-bit eForth1 memory bus.
//   ASZ / DSZ    bus address / data widths (128K x 8 byte RAM)
//   mb8_st_e     word-master sequencer states
//   mb8_req_t    request fields captured when an access is accepted
package mb8_pkg;

  localparam int ASZ = 17;
  localparam int DSZ = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    B0   = 3'd1,  // first bus cycle, byte at addr
    B1   = 3'd2,  // second bus cycle, byte at addr+1 (cell accesses only)
    RL   = 3'd3,  // read-latency cycle, last byte arrives from the RAM
    DONE = 3'd4   // completion, ack pulse
  } mb8_st_e;

  typedef struct packed {
    logic           wr;
    logic           bw;
    logic [ASZ-1:0] addr;
    logic [15:0]    wdata;
  } mb8_req_t;

endpackage

// File: rtl/mb8_word_master_if.sv
// mb8_io: byte-wide bus between the word master and the byte RAM.
//   ai  byte address        (master -> RAM)
//   vi  write data          (master -> RAM)
//   we  write enable        (master -> RAM)
//   vo  read data, 1 cycle after ai is sampled (RAM -> master)
interface mb8_io;
  import mb8_pkg::*;

  logic [ASZ-1:0] ai;
  logic [DSZ-1:0] vi;
  logic           we;
  logic [DSZ-1:0] vo;

  modport master (output ai, output vi, output we, input vo);
  modport slave  (input ai, input vi, input we, output vo);
endinterface

// File: rtl/spram8_128k.sv
// spram8_128k: 128K x 8 single-port synchronous RAM serving the mb8 bus.
//   clk  rising-edge clock
//   bus  mb8_io slave: write vi to ai when we=1; vo shows the byte at the
//        address sampled on the previous edge (read-before-write).
module spram8_128k (
  input logic   clk,
  mb8_io.slave  bus
);
  import mb8_pkg::*;

  // NOTE: the storage array has no reset; RAM contents are undefined until written.
  logic [DSZ-1:0] mem [0:(2**ASZ)-1];

  always_ff @(posedge clk) begin
    if (bus.we) mem[bus.ai] <= bus.vi;
    bus.vo <= mem[bus.ai];
  end
endmodule

// File: rtl/mb8_word_master.sv
// mb8_word_master: turns eForth @ ! C@ C! requests into byte-wide bus cycles.
// Cells are big-endian (high byte at addr, low byte at addr+1, ASZ-bit wrap).
//   clk, rst_n  clock, asynchronous active-low reset
//   req         start an access (sampled only when idle)
//   wr, bw      1 = write / 1 = byte access; latched with req
//   addr, wdata byte address, write data (byte writes use wdata[7:0])
//   busy        high in every non-idle state
//   ack         one-cycle completion pulse
//   rdata       read result, held until the next read completes
//   mem         mb8_io master port to the byte RAM
// Every output comes straight from a flop: the bus values for a state are
// computed from the next state and registered on the edge that enters it.
module mb8_word_master
  import mb8_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic           wr,
  input  logic           bw,
  input  logic [ASZ-1:0] addr,
  input  logic [15:0]    wdata,
  output logic           busy,
  output logic           ack,
  output logic [15:0]    rdata,
  mb8_io.master          mem
);

  mb8_st_e        state_q, state_d;
  mb8_req_t       req_q, req_d;
  logic [ASZ-1:0] ai_q, ai_d;
  logic [DSZ-1:0] vi_q, vi_d;
  logic           we_q, we_d;
  logic [15:0]    rdata_q, rdata_d;
  logic           busy_d, ack_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    req_d   = req_q;
    ai_d    = ai_q;
    vi_d    = vi_q;
    we_d    = 1'b0;
    rdata_d = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          req_d   = '{wr: wr, bw: bw, addr: addr, wdata: wdata};
          state_d = B0;
          ai_d    = addr;
          if (wr) begin
            we_d = 1'b1;
            vi_d = bw ? wdata[7:0] : wdata[15:8];
          end
        end
      end
      B0: begin
        if (req_q.bw) begin
          state_d = req_q.wr ? DONE : RL;
        end else begin
          state_d = B1;
          ai_d    = req_q.addr + ASZ'(1);
          if (req_q.wr) begin
            we_d = 1'b1;
            vi_d = req_q.wdata[7:0];
          end
        end
      end
      B1: begin
        if (req_q.wr) begin
          state_d = DONE;
        end else begin
          // Byte at addr was sampled by the RAM at the end of B0.
          rdata_d[15:8] = mem.vo;
          state_d       = RL;
        end
      end
      RL: begin
        rdata_d[7:0] = mem.vo;
        if (req_q.bw) rdata_d[15:8] = 8'h00;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    ack_d  = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      ai_q    <= '0;
      vi_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      busy    <= 1'b0;
      ack     <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ai_q    <= ai_d;
      vi_q    <= vi_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      busy    <= busy_d;
      ack     <= ack_d;
    end
  end

  assign mem.ai = ai_q;
  assign mem.vi = vi_q;
  assign mem.we = we_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_mb8_word_master.sv
// tb_mb8_word_master: directed and randomized accesses against a byte-array
// model of memory; a scoreboard queue holds each access's expected response
// and a negedge monitor pops it whenever ack is seen.
module tb_mb8_word_master;
  import mb8_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           req = 1'b0;
  logic           wr = 1'b0;
  logic           bw = 1'b0;
  logic [ASZ-1:0] addr = '0;
  logic [15:0]    wdata = '0;
  logic           busy, ack;
  logic [15:0]    rdata;

  mb8_io mem_if ();

  mb8_word_master dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .wr    (wr),
    .bw    (bw),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .ack   (ack),
    .rdata (rdata),
    .mem   (mem_if.master)
  );

  spram8_128k ram (
    .clk (clk),
    .bus (mem_if.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t    sb[$];
  time         ack_times[$];
  logic [7:0]  model [0:(2**ASZ)-1];
  int          total = 0;
  int          bad = 0;
  int          ack_count = 0;
  int          issued = 0;
  bit          saw_300 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_addr(input int a);
    return (a + 1) % (2**ASZ);
  endfunction

  // Reference behaviour: update the byte array for writes, predict rdata for reads.
  function automatic sb_item_t model_access(input bit w, input bit b, input int a, input logic [15:0] d);
    sb_item_t e;
    e.rd  = !w;
    e.exp = 16'h0000;
    if (w) begin
      if (b) model[a] = d[7:0];
      else begin
        model[a]            = d[15:8];
        model[next_addr(a)] = d[7:0];
      end
    end else begin
      e.exp = b ? {8'h00, model[a]} : {model[a], model[next_addr(a)]};
    end
    return e;
  endfunction

  // Busy length: one cycle per byte moved, one more for read latency, one for DONE.
  function automatic int busy_len(input bit w, input bit b);
    return (b ? 1 : 2) + (w ? 0 : 1) + 1;
  endfunction

  // Monitor / scoreboard: compares whenever the DUT acknowledges.
  always @(negedge clk) begin
    if (rst_n && ack === 1'b1) begin
      ack_count++;
      ack_times.push_back($time);
      if (sb.size() == 0) check("spurious_ack", 32'd1, 32'd0);
      else begin
        sb_item_t e;
        e = sb.pop_front();
        if (e.rd) check("rdata", {16'h0, rdata}, {16'h0, e.exp});
      end
    end
    if (mem_if.ai === 17'h00300) saw_300 = 1'b1;
  end

  // Starts at any time; returns at a negedge with the DUT idle.
  task automatic do_access(input bit w, input bit b, input int a, input logic [15:0] d);
    int n;
    @(negedge clk);
    req = 1'b1; wr = w; bw = b; addr = ASZ'(a); wdata = d;
    sb.push_back(model_access(w, b, a, d));
    issued++;
    @(posedge clk);
    #1;
    req = 1'b0; addr = 'x; wdata = 'x;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check($sformatf("busy_cycles w=%0d b=%0d a=%h", w, b, a), n, busy_len(w, b));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_before;
    int n_b2b;
    // Reset state
    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_rdata", {16'h0, rdata}, 32'h0);
    check("rst_ai", {15'h0, mem_if.ai}, 32'h0);
    check("rst_vi", {24'h0, mem_if.vi}, 32'h0);
    check("rst_we", {31'h0, mem_if.we}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word write then read, plus byte views of the same cell
    do_access(1, 0, 32'h10, 16'h1234);
    do_access(0, 0, 32'h10, 16'h0000);
    do_access(0, 1, 32'h10, 16'h0000);
    do_access(0, 1, 32'h11, 16'h0000);

    // Byte ops against a known high byte
    do_access(1, 0, 32'h20, 16'h5A00);
    do_access(1, 1, 32'h21, 16'hFFA5);
    do_access(0, 0, 32'h20, 16'h0000);
    do_access(0, 1, 32'h21, 16'h0000);

    // Address wrap at the top of memory
    do_access(1, 0, 32'h1FFFF, 16'hBEEF);
    do_access(0, 1, 32'h1FFFF, 16'h0000);
    do_access(0, 1, 32'h00000, 16'h0000);
    do_access(0, 0, 32'h1FFFF, 16'h0000);

    // Back-to-back with req held high
    @(negedge clk);
    ack_before = ack_count;
    n_b2b = ack_times.size();
    req = 1'b1; wr = 1'b1; bw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr  = ASZ'(32'h100 + 2 * i);
      wdata = {8'(2 * i + 1), 8'(2 * i + 2)};
      sb.push_back(model_access(1, 0, 32'h100 + 2 * i, wdata));
      issued++;
      @(posedge clk);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (!busy) break;
      end
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_ack_count", ack_count - ack_before, 32'd4);
    for (int i = 1; i < 4; i++)
      if (ack_times.size() > n_b2b + i)
        check($sformatf("b2b_ack_spacing%0d", i),
              32'(ack_times[n_b2b + i] - ack_times[n_b2b + i - 1]), 32'd40);
    for (int i = 0; i < 4; i++) do_access(0, 0, 32'h100 + 2 * i, 16'h0000);

    // Reset in B1 of a word write
    @(negedge clk);
    ack_before = ack_count;
    req = 1'b1; wr = 1'b1; bw = 1'b0; addr = 17'h00200; wdata = 16'hC33C;
    @(posedge clk);  // accept -> B0
    #1 req = 1'b0;
    @(posedge clk);  // B0 -> B1, high byte written
    #1 rst_n = 1'b0;
    #1;
    check("abort_we", {31'h0, mem_if.we}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_ack", {31'h0, ack}, 32'h0);
    check("abort_rdata", {16'h0, rdata}, 32'h0);
    model[32'h200] = 8'hC3;
    @(negedge clk);
    rst_n = 1'b1;
    do_access(0, 1, 32'h200, 16'h0000);
    check("abort_acks", ack_count - ack_before, 32'd1);

    // Req pulsed during busy is ignored
    @(negedge clk);
    ack_before = ack_count;
    saw_300 = 1'b0;
    req = 1'b1; wr = 1'b1; bw = 1'b0; addr = 17'h00280; wdata = 16'h1111;
    sb.push_back(model_access(1, 0, 32'h280, 16'h1111));
    issued++;
    @(posedge clk);  // -> B0
    #1 req = 1'b0;
    @(posedge clk);  // -> B1
    #1 req = 1'b1; wr = 1'b0; bw = 1'b0; addr = 17'h00300;
    @(posedge clk);  // -> DONE
    @(posedge clk);  // -> IDLE
    #1 req = 1'b0; addr = 'x;
    repeat (6) @(negedge clk);
    check("busy_req_acks", ack_count - ack_before, 32'd1);
    check("busy_req_no_0x300", {31'h0, saw_300}, 32'h0);

    // Randomized traffic inside an initialized window
    for (int i = 0; i < 32; i++) do_access(1, 0, 32'h400 + 2 * i, 16'($urandom));
    for (int i = 0; i < 48; i++)
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'h400 + $urandom_range(0, 62), 16'($urandom));

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    check("ack_total", ack_count, issued);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mb8_word_master.md
Name: mb8_word_master

Overview:
- Initiator side of the 8-bit eForth1 memory bus that the 128K single-port byte RAM (spram8_128k) serves.
- Converts 16-bit cell accesses and 8-bit char accesses (eForth @ ! C@ C!) into byte-wide bus cycles.
- Sits between the eForth1 core's load/store unit and the byte RAM.
- Cells are big-endian: high byte at addr, low byte at addr+1.

Parameters:
- ASZ, 17, bus address width in bits (128K bytes).
- DSZ, 8, bus data width in bits.

Ports:
- clk  input  1  system clock; everything is sampled on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  1  access request; sampled only in IDLE.
- wr  input  1  1 = write, 0 = read; latched with req.
- bw  input  1  1 = byte (char) access, 0 = 16-bit cell access; latched with req.
- addr  input  ASZ  byte address; latched with req.
- wdata  input  16  write data; byte writes use wdata[7:0]; latched with req.
- busy  output  1  high in every non-IDLE state.
- ack  output  1  one-cycle pulse on completion.
- rdata  output  16  read result; valid while ack=1 and held until the next read completes.
- mem_ai  output  ASZ  bus address to the RAM.
- mem_vi  output  DSZ  bus write data to the RAM.
- mem_we  output  1  bus write enable to the RAM.
- mem_vo  input  DSZ  bus read data from the RAM; 1-cycle latency (data for mem_ai seen at edge N appears after edge N).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, ack=0, rdata=0; mem_ai=0, mem_vi=0, mem_we=0.
  - A reset mid-access aborts it immediately. mem_we drops to 0 asynchronously; no ack is issued; a partially written cell is left as is.
- All bus outputs and busy/ack are registered; no combinational path from req to the bus.
- States: IDLE, B0, B1, RL, DONE.
  - IDLE, req=1 at edge: latch wr/bw/addr/wdata and go to B0.
  - B0: mem_ai=A.
    - Write: mem_we=1; mem_vi = bw ? wdata[7:0] : wdata[15:8]; next = bw ? DONE : B1.
    - Read: mem_we=0; next = bw ? RL : B1.
  - B1: mem_ai=A+1 (ASZ-bit wrap: 0x1FFFF+1 = 0x00000).
    - Write: mem_we=1, mem_vi=wdata[7:0], next DONE.
    - Read: mem_we=0; at exit edge capture rdata[15:8]=mem_vo; next RL.
  - RL (read only): mem_we=0.
    - At exit edge capture rdata[7:0]=mem_vo.
    - Byte read also clears rdata[15:8]=0.
    - Next DONE.
  - DONE: mem_we=0, ack=1, next IDLE.
- Busy cycles from the accept edge to IDLE:
  - byte write 2 (B0, DONE)
  - word write 3 (B0, B1, DONE)
  - byte read 3 (B0, RL, DONE)
  - word read 4 (B0, B1, RL, DONE)
- req is ignored while busy=1, including in DONE. A held req starts a new access on the first IDLE edge, so back-to-back throughput is one access per (busy cycles + 1).
- mem_ai and mem_vi hold their last values in IDLE and DONE; mem_we is 0 outside the write states.
- Odd addresses are legal; no alignment is imposed.
- An X on addr or wdata while req=0 in IDLE has no effect.

Decomposition:
- Package mb8_pkg:
  - ASZ=17, DSZ=8.
  - Typedef mb8_st_e {IDLE, B0, B1, RL, DONE}.
  - Typedef for the latched request struct {wr, bw, addr, wdata}.
- Single module; no sub-module. The bench instantiates spram8_128k as the slave, with mem_* wired to the mb8_io signals ai/vi/we/vo.

Test Plan:
- Word write then read: write addr=0x00010, wdata=0x1234; read 0x00010 → rdata=0x1234. Direct byte reads of 0x10 → 0x12 and 0x11 → 0x34. Busy for 3 cycles on the write and 4 on the read; ack pulses exactly once per access.
- Byte ops: byte write 0x00021 ← 0xA5, then word read 0x00020 → rdata[7:0]=0xA5 with the high byte unchanged from the prior content. Byte read 0x00021 → 0x00A5.
- Wrap-around: word write addr=0x1FFFF, wdata=0xBEEF. Byte read 0x1FFFF → 0x00BE; byte read 0x00000 → 0x00EF; word read 0x1FFFF → 0xBEEF.
- Back-to-back with req held high: 4 word writes to 0x100, 0x102, 0x104, 0x106 with values 0x0102..0x0708. Exactly 4 ack pulses, 4 cycles apart. Read-back of each word matches.
- Reset mid-access: assert rst_n=0 during B1 of a word write to 0x200. mem_we=0 in the same timestep; busy=0, ack=0, rdata=0. After release, byte read 0x200 → the new high byte; no spurious ack.
- Req during busy: pulse a second req (read 0x300) in B1 of a write. It is ignored: only one ack, and mem_ai never equals 0x300.
